pellet_eater: RTL and testbench
===============================

// Module: pellet_eater
// PURPOSE
//   Initiator for the pellet map's read/clear port (port B). After reset it scans all 32x32 cells to count pellets.
//   It then services tile-entry requests from player movement logic. Each request reads the cell; if a pellet is
//   present, it clears the cell, adds points to the score and decrements the remaining count. Flags level clear.
// PARAMETERS
//   POINTS    10   score increment per pellet eaten
//   SCORE_W   16   score width; score saturates at all-ones
// PORTS
//   clk          in   1        clock
//   reset        in   1        synchronous, active-high; shared with pellet map (map reloads on same edge)
//   tile_valid   in   1        request: player entered tile (tile_x,tile_y); held until accepted
//   tile_x       in   5        column of request
//   tile_y       in   5        row of request
//   tile_ready   out  1        request accepted on edge where tile_valid&tile_ready
//   mem_x        out  5        port B column (xpos_b)
//   mem_y        out  5        port B row (ypos_b)
//   mem_clear    out  1        port B clear (clear_b); clears cell at edge, out_b holds
//   mem_rd       in   1        port B read data (out_b); registered, valid 1 cycle after address when clear=0
//   eaten        out  1        1-cycle pulse: pellet consumed at latched tile
//   score        out  SCORE_W  accumulated score
//   remaining    out  11       pellets left (0..1024)
//   scan_done    out  1        initial count complete; sticky until reset
//   level_clear  out  1        scan_done & remaining==0; sticky until reset
// BEHAVIOUR
//   Reset values: tile_ready=0, mem_x=mem_y=0, mem_clear=0, eaten=0, score=0, remaining=0, scan_done=0,
//     level_clear=0; state=SCAN, scan counter cnt=0. Reset mid-operation aborts any access and restarts SCAN.
//   States: SCAN -> SCAN_TAIL -> IDLE -> READ -> CHECK -> (EAT ->) IDLE.
//   SCAN: drive mem_x=cnt[4:0], mem_y=cnt[9:5], mem_clear=0; cnt increments every cycle. From cycle 2 of SCAN,
//     if mem_rd=1 then remaining+1 (data for address of previous cycle). When cnt=1023 -> SCAN_TAIL.
//   SCAN_TAIL: count final mem_rd, then set scan_done -> IDLE. Total 1025 cycles from reset release to scan_done=1.
//   IDLE: tile_ready=1 unless level_clear. On accept, latch tile_x/tile_y -> READ.
//   READ: mem_x/mem_y=latched tile, mem_clear=0 -> CHECK.
//   CHECK: same address; mem_rd is the cell value. mem_rd=1 -> EAT; otherwise -> IDLE.
//   EAT: mem_clear=1 at latched address and eaten=1 for exactly this cycle.
//     At the EAT edge: score+=POINTS, saturating at 2^SCORE_W-1; remaining-=1 (never underflows); -> IDLE.
//   Latency: accept at edge T; EAT is the cycle after edge T+2; new score/remaining are visible after EAT's edge.
//     Tile accepted every 3 cycles (empty cell) or 4 cycles (pellet) max throughput.
//   tile_ready=0 in all states except IDLE. Requests during busy are not lost; they are held by the requester.
//   level_clear is set combinationally-registered on the edge where remaining becomes 0 after scan_done.
//     An empty map raises it at the end of the scan. Once set, it blocks further requests until reset.
//   mem_clear is never asserted outside EAT. Only one port-B access per cycle.
//   The address is stable across READ/CHECK/EAT.
//   Out-of-map tiles (rows 0x1C-0x1F etc.) are legal; they read 0 and do nothing.
// TESTING
//   1 Release reset with default map -> scan_done rises 1025 cycles later; remaining = popcount of map reset image.
//   2 After scan, tile (2,2) -> eaten pulse 3 cycles after accept; mem_clear=1 at (2,2) that cycle;
//     score=10; remaining decreases by 1.
//   3 Repeat tile (2,2) -> no eaten, no mem_clear, score stays 10, tile_ready back after 3 cycles.
//   4 tile (0,0) (empty) and tile (31,31) -> no eaten, no clear, counts unchanged.
//   5 Map model with 1 pellet at (5,9): eat it -> remaining=0, level_clear=1, tile_ready stays 0.
//     Also, SCORE_W=4 with POINTS=10: two pellets -> score=15 (saturated).
//   6 Assert reset during EAT -> next cycle all outputs at reset values.
//     Rescan restores full remaining count and the cell at (2,2) is readable as 1 again.

Source files
------------

// File: rtl/pellet_eater.sv
// Port-B initiator for the pellet map: counts pellets after reset, then
// services tile-entry requests by reading and, if set, clearing the cell.
module pellet_eater #(
  parameter int POINTS  = 10,
  parameter int SCORE_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tile_valid,
  input  logic [4:0]         tile_x,
  input  logic [4:0]         tile_y,
  output logic               tile_ready,
  output logic [4:0]         mem_x,
  output logic [4:0]         mem_y,
  output logic               mem_clear,
  input  logic               mem_rd,
  output logic               eaten,
  output logic [SCORE_W-1:0] score,
  output logic [10:0]        remaining,
  output logic               scan_done,
  output logic               level_clear
);

  typedef enum logic [2:0] {SCAN, SCAN_TAIL, IDLE, READ, CHECK, EAT} state_t;

  localparam int SW = SCORE_W + 32;
  localparam logic [SW-1:0] SCORE_MAX = SW'({SCORE_W{1'b1}});

  state_t             state;
  logic [9:0]         cnt;
  logic [SW-1:0]      score_sum;
  logic [SCORE_W-1:0] score_inc;
  logic [10:0]        rem_scan;
  logic [10:0]        rem_dec;

  // Wide add so any POINTS value saturates correctly.
  assign score_sum = SW'(score) + SW'(POINTS);
  assign score_inc = (score_sum > SCORE_MAX) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
  assign rem_scan  = remaining + 11'(mem_rd);
  assign rem_dec   = (remaining == 11'd0) ? 11'd0 : remaining - 11'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SCAN;
      cnt         <= 10'd0;
      tile_ready  <= 1'b0;
      mem_x       <= 5'd0;
      mem_y       <= 5'd0;
      mem_clear   <= 1'b0;
      eaten       <= 1'b0;
      score       <= '0;
      remaining   <= 11'd0;
      scan_done   <= 1'b0;
      level_clear <= 1'b0;
    end else begin
      mem_clear <= 1'b0;
      eaten     <= 1'b0;
      case (state)
        SCAN: begin
          // Read data lags the address by one cycle; nothing valid at cnt==0.
          if (cnt != 10'd0) remaining <= rem_scan;
          cnt <= cnt + 10'd1;
          if (cnt == 10'h3FF) state <= SCAN_TAIL;
          else {mem_y, mem_x} <= cnt + 10'd1;
        end
        SCAN_TAIL: begin
          remaining   <= rem_scan;
          scan_done   <= 1'b1;
          level_clear <= (rem_scan == 11'd0);
          tile_ready  <= (rem_scan != 11'd0);
          state       <= IDLE;
        end
        IDLE: begin
          if (tile_valid && tile_ready) begin
            tile_ready <= 1'b0;
            mem_x      <= tile_x;
            mem_y      <= tile_y;
            state      <= READ;
          end
        end
        READ: state <= CHECK;
        CHECK: begin
          if (mem_rd) begin
            mem_clear <= 1'b1;
            eaten     <= 1'b1;
            state     <= EAT;
          end else begin
            tile_ready <= !level_clear;
            state      <= IDLE;
          end
        end
        EAT: begin
          score     <= score_inc;
          remaining <= rem_dec;
          if (rem_dec == 11'd0) level_clear <= 1'b1;
          tile_ready <= (rem_dec != 11'd0) && !level_clear;
          state      <= IDLE;
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_pellet_eater.sv
// Bench for pellet_eater: behavioural pellet maps, reference model and a
// scoreboard monitor checking each accepted tile request.
module tb_pellet_eater;
  localparam int MAXS = (1 << 16) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tile_valid = 1'b0;
  logic [4:0] tile_x = '0, tile_y = '0;
  logic tile_ready, mem_clear, mem_rd, eaten, scan_done, level_clear;
  logic [4:0] mem_x, mem_y;
  logic [15:0] score;
  logic [10:0] remaining;

  logic tile_valid2 = 1'b0;
  logic [4:0] tile_x2 = '0, tile_y2 = '0;
  logic tile_ready2, mem_clear2, mem_rd2, eaten2, scan_done2, level_clear2;
  logic [4:0] mem_x2, mem_y2;
  logic [3:0] score2;
  logic [10:0] remaining2;

  int img_sel = 0;
  bit map1 [32][32];
  bit map2 [32][32];
  int checks = 0, errors = 0, cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {int x; int y; bit eat; int score; int rem; bit lc; int acc;} exp_t;
  exp_t sb[$];
  exp_t infl[$];

  bit rmap [32][32];
  int r_score, r_rem;
  bit r_lc;

  pellet_eater #(.POINTS(10), .SCORE_W(16)) u_dut (
    .clk(clk), .reset(reset), .tile_valid(tile_valid), .tile_x(tile_x), .tile_y(tile_y),
    .tile_ready(tile_ready), .mem_x(mem_x), .mem_y(mem_y), .mem_clear(mem_clear),
    .mem_rd(mem_rd), .eaten(eaten), .score(score), .remaining(remaining),
    .scan_done(scan_done), .level_clear(level_clear));

  pellet_eater #(.POINTS(10), .SCORE_W(4)) u_dut2 (
    .clk(clk), .reset(reset), .tile_valid(tile_valid2), .tile_x(tile_x2), .tile_y(tile_y2),
    .tile_ready(tile_ready2), .mem_x(mem_x2), .mem_y(mem_y2), .mem_clear(mem_clear2),
    .mem_rd(mem_rd2), .eaten(eaten2), .score(score2), .remaining(remaining2),
    .scan_done(scan_done2), .level_clear(level_clear2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit img_bit(input int sel, input int x, input int y);
    case (sel)
      0: return (y < 28) && ((x + y) % 3 != 0);
      1: return (x == 5) && (y == 9);
      2: return ((x == 1) && (y == 1)) || ((x == 3) && (y == 3));
      default: return 1'b0;
    endcase
  endfunction

  // Pellet map port B: registered read, clear holds read data, reload on reset.
  always @(posedge clk) begin
    if (reset) begin
      for (int y = 0; y < 32; y++)
        for (int x = 0; x < 32; x++) begin
          map1[y][x] <= img_bit(img_sel, x, y);
          map2[y][x] <= img_bit(2, x, y);
        end
      mem_rd  <= 1'b0;
      mem_rd2 <= 1'b0;
    end else begin
      if (mem_clear) map1[mem_y][mem_x] <= 1'b0;
      else mem_rd <= map1[mem_y][mem_x];
      if (mem_clear2) map2[mem_y2][mem_x2] <= 1'b0;
      else mem_rd2 <= map2[mem_y2][mem_x2];
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_load(input int sel);
    r_rem = 0;
    r_score = 0;
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++) begin
        rmap[y][x] = img_bit(sel, x, y);
        r_rem += int'(rmap[y][x]);
      end
    r_lc = (r_rem == 0);
  endtask

  task automatic do_reset(input int sel);
    int n;
    n = 0;
    mon_en = 1'b0;
    img_sel = sel;
    reset = 1'b1;
    tile_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("reset_state", {tile_ready, mem_x, mem_y, mem_clear, eaten, score, remaining,
                           scan_done, level_clear}, 0);
    model_load(sel);
    reset = 1'b0;
    while (!scan_done && n < 1100) begin @(posedge clk); #1; n++; end
    chk("scan_cycles", n, 1025);
    chk("scan_remaining", remaining, r_rem);
    chk("scan_level_clear", level_clear, r_lc);
    sb.delete();
    infl.delete();
    mon_en = 1'b1;
  endtask

  // Issue one request; the expected outcome comes from the reference map.
  task automatic req(input int x, input int y);
    exp_t e;
    int n;
    n = 0;
    e.x = x; e.y = y; e.acc = 0;
    e.eat = rmap[y][x];
    if (e.eat) begin
      rmap[y][x] = 1'b0;
      r_score = (r_score + 10 > MAXS) ? MAXS : r_score + 10;
      if (r_rem > 0) r_rem--;
      if (r_rem == 0) r_lc = 1'b1;
    end
    e.score = r_score; e.rem = r_rem; e.lc = r_lc;
    sb.push_back(e);
    tile_valid = 1'b1; tile_x = 5'(x); tile_y = 5'(y);
    @(negedge clk);
    while (!tile_ready && n < 40) begin @(negedge clk); n++; end
    if (!tile_ready) begin
      chk("accept_timeout", 0, 1);
      void'(sb.pop_back());
      tile_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 tile_valid = 1'b0;
  endtask

  task automatic req2(input int x, input int y, input int exp_score, input int exp_rem);
    int n;
    n = 0;
    tile_valid2 = 1'b1; tile_x2 = 5'(x); tile_y2 = 5'(y);
    @(negedge clk);
    while (!tile_ready2 && n < 40) begin @(negedge clk); n++; end
    chk("dut2_accept", tile_ready2, 1);
    @(posedge clk);
    #1 tile_valid2 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("dut2_score", score2, exp_score);
    chk("dut2_remaining", remaining2, exp_rem);
  endtask

  task automatic drain();
    repeat (8) @(posedge clk);
    #1 chk("drain", infl.size() + sb.size(), 0);
  endtask

  // Monitor: pairs each accept with its expectation, checks EAT cycle and result.
  always @(negedge clk) begin : mon
    bit clr_exp;
    exp_t f, e;
    clr_exp = 1'b0;
    if (mon_en && !reset) begin
      if (infl.size() > 0) begin
        f = infl[0];
        if (cyc == f.acc + 3) begin
          clr_exp = f.eat;
          if (f.eat) chk("eat_addr", {mem_y, mem_x}, f.y * 32 + f.x);
          else chk("ready_after_empty", tile_ready, 1);
        end
        if (cyc == f.acc + 4) begin
          chk("score", score, f.score);
          chk("remaining", remaining, f.rem);
          chk("level_clear", level_clear, f.lc);
          if (f.eat) chk("ready_after_eat", tile_ready, !f.lc);
          void'(infl.pop_front());
        end
      end
      chk("mem_clear", mem_clear, clr_exp);
      chk("eaten", eaten, clr_exp);
      if (tile_valid && tile_ready) begin
        if (sb.size() == 0) chk("unexpected_accept", 0, 1);
        else begin
          e = sb.pop_front();
          e.acc = cyc;
          infl.push_back(e);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, g;
    do_reset(0);
    chk("dut2_scan", remaining2, 2);
    req(2, 2);
    req(2, 2);
    req(0, 0);
    req(31, 31);
    for (int i = 0; i < 60; i++) begin
      g = $urandom_range(0, 3);
      repeat (g) begin @(posedge clk); #1; end
      req($urandom_range(0, 31), $urandom_range(0, 31));
    end
    drain();

    req2(1, 1, 10, 1);
    req2(3, 3, 15, 0);
    chk("dut2_level_clear", level_clear2, 1);

    do_reset(1);
    req(5, 9);
    drain();
    tile_valid = 1'b1; tile_x = 5'd5; tile_y = 5'd9;
    n = 0;
    repeat (10) begin @(negedge clk); if (tile_ready) n++; end
    chk("ready_blocked", n, 0);
    tile_valid = 1'b0;

    do_reset(3);

    do_reset(0);
    mon_en = 1'b0;
    tile_valid = 1'b1; tile_x = 5'd2; tile_y = 5'd2;
    n = 0;
    do begin @(negedge clk); n++; end while (!eaten && n < 20);
    chk("eat_seen", eaten, 1);
    reset = 1'b1;
    @(posedge clk);
    #1 chk("reset_in_eat", {tile_ready, mem_x, mem_y, mem_clear, eaten, score, remaining,
                            scan_done, level_clear}, 0);
    do_reset(0);
    req(2, 2);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
